// File: rtl/lif_layer.sv
`default_nettype none
// ============================================================================
// Module   : lif_layer
// Purpose  : Chain of N_NEURONS leaky integrate-and-fire neurons with a
//            refractory period. Neuron 0 integrates the external current;
//            neuron k>0 integrates `weight` whenever neuron k-1 spiked on the
//            previous enabled edge. A probe mux exposes one membrane state.
// Ports    : clk         - rising-edge clock
//            rst_n       - asynchronous active-low reset
//            en          - advance all neurons this cycle
//            current     - input current of neuron 0
//            weight      - synaptic weight between chained neurons
//            probe_sel   - neuron index routed to state_out
//            spike       - registered one-cycle spike pulses, bit k = neuron k
//            state_out   - membrane state of neuron probe_sel (0 if out of range)
//            spike_count - saturating spike total of the last neuron
// Options  : LIF_SPIKE_COUNT_EN - when defined, spike_count is a 16-bit
//            saturating counter; otherwise it is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module lif_layer #(
  parameter int WIDTH      = 8,
  parameter int N_NEURONS  = 2,
  parameter int BETA_SHIFT = 1,
  parameter int THRESHOLD  = 200,
  parameter int REFRACT    = 2,
  localparam int PSEL_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [WIDTH-1:0]     current,
  input  logic [WIDTH-1:0]     weight,
  input  logic [PSEL_W-1:0]    probe_sel,
  output logic [N_NEURONS-1:0] spike,
  output logic [WIDTH-1:0]     state_out,
  output logic [15:0]          spike_count
);

  localparam logic [WIDTH:0] THRESH_V = (WIDTH + 1)'(THRESHOLD);
  localparam logic [7:0]     REFR_V   = 8'(REFRACT);

  logic [N_NEURONS-1:0] spike_w;
  logic [WIDTH-1:0]     state_w [N_NEURONS];

  for (genvar k = 0; k < N_NEURONS; k++) begin : g_neuron
    logic [WIDTH-1:0] state_q, state_d;
    logic [7:0]       refr_q, refr_d;
    logic             spike_q, spike_d;
    logic [WIDTH-1:0] in_w;
    logic [WIDTH-1:0] leaked_w;
    logic [WIDTH:0]   sum_w;

    if (k == 0) begin : g_src_ext
      assign in_w = current;
    end else begin : g_src_chain
      // Registered spike of the previous stage: one cycle of latency per stage.
      assign in_w = spike_w[k-1] ? weight : '0;
    end

    // state - (state >> s) never underflows, so the leak fits in WIDTH bits;
    // the extra sum bit keeps leak + input from wrapping before the compare.
    assign leaked_w = state_q - (state_q >> BETA_SHIFT);
    assign sum_w    = {1'b0, leaked_w} + {1'b0, in_w};

    always_comb begin
      state_d = state_q;
      refr_d  = refr_q;
      spike_d = 1'b0;
      if (en) begin
        if (refr_q != 8'd0) begin
          refr_d  = refr_q - 8'd1;
          state_d = '0;
        end else if (sum_w >= THRESH_V) begin
          spike_d = 1'b1;
          state_d = '0;
          refr_d  = REFR_V;
        end else begin
          // Below threshold, so sum < 2**WIDTH and the truncation is exact.
          state_d = sum_w[WIDTH-1:0];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= '0;
        refr_q  <= '0;
        spike_q <= 1'b0;
      end else begin
        state_q <= state_d;
        refr_q  <= refr_d;
        spike_q <= spike_d;
      end
    end

    assign spike_w[k] = spike_q;
    assign state_w[k] = state_q;
  end

  assign spike = spike_w;

  // Explicit compare per neuron so out-of-range selects read back zero.
  always_comb begin
    state_out = '0;
    for (int k = 0; k < N_NEURONS; k++) begin
      if (probe_sel == PSEL_W'(k)) begin
        state_out = state_w[k];
      end
    end
  end

`ifdef LIF_SPIKE_COUNT_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (spike_w[N_NEURONS-1] && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign spike_count = count_q;
`else
  assign spike_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lif_layer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lif_layer
// Purpose  : Self-checking bench for lif_layer (WIDTH=8, N_NEURONS=2,
//            BETA_SHIFT=1, THRESHOLD=200, REFRACT=2). Table-driven directed
//            vectors, hand-written reset/refractory sequences and a random
//            phase compared against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lif_layer;
  localparam int W    = 8;
  localparam int N    = 2;
  localparam int BS   = 1;
  localparam int TH   = 200;
  localparam int REFR = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [W-1:0]  current = '0;
  logic [W-1:0]  weight = '0;
  logic [0:0]    probe_sel = '0;
  logic [N-1:0]  spike;
  logic [W-1:0]  state_out;
  logic [15:0]   spike_count;

  int checks = 0;
  int errors = 0;

  lif_layer #(
    .WIDTH(W), .N_NEURONS(N), .BETA_SHIFT(BS), .THRESHOLD(TH), .REFRACT(REFR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .current(current), .weight(weight),
    .probe_sel(probe_sel), .spike(spike), .state_out(state_out),
    .spike_count(spike_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b1; current = 8'd255; weight = 8'd255;
    for (int i = 0; i < 3; i++) begin
      probe_sel = 1'(i);
      step();
      chk("reset_spike", int'(spike), 0);
      chk("reset_state", int'(state_out), 0);
      chk("reset_count", int'(spike_count), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  int m_st[N];
  int m_rf[N];
  int m_sp[N];
  int m_cnt;

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      m_st[k] = 0; m_rf[k] = 0; m_sp[k] = 0;
    end
    m_cnt = 0;
  endfunction

  function automatic void model_step(input bit e, input int cur, input int w);
    int nsp[N];
    int inp, sum;
`ifdef LIF_SPIKE_COUNT_EN
    if (m_sp[N-1] != 0 && m_cnt < 65535) m_cnt = m_cnt + 1;
`endif
    for (int k = 0; k < N; k++) begin
      nsp[k] = 0;
      if (e) begin
        inp = (k == 0) ? cur : ((m_sp[k-1] != 0) ? w : 0);
        if (m_rf[k] > 0) begin
          m_rf[k] = m_rf[k] - 1;
          m_st[k] = 0;
        end else begin
          sum = m_st[k] - m_st[k] / (2 ** BS) + inp;
          if (sum >= TH) begin
            nsp[k] = 1; m_st[k] = 0; m_rf[k] = REFR;
          end else begin
            m_st[k] = sum;
          end
        end
      end
    end
    for (int k = 0; k < N; k++) m_sp[k] = nsp[k];
  endfunction

  function automatic int model_spike_vec();
    int v = 0;
    for (int k = 0; k < N; k++) v = v | (m_sp[k] << k);
    return v;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rst;        // reset the DUT before applying this vector
    bit en;
    int cur;
    int wt;
    int psel;
    int exp_state;
    int exp_spike;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit r, input bit e, input int c, input int w,
                              input int p, input int es, input int sp);
    vec_t v;
    v.rst = r; v.en = e; v.cur = c; v.wt = w; v.psel = p;
    v.exp_state = es; v.exp_spike = sp;
    tbl.push_back(v);
  endfunction

  initial begin
    int exp_count;
    // Leak convergence: current=100 from rest.
    add(1, 1, 100, 0, 0, 100, 0);
    add(0, 1, 100, 0, 0, 150, 0);
    add(0, 1, 100, 0, 0, 175, 0);
    add(0, 1, 100, 0, 0, 188, 0);
    add(0, 1, 100, 0, 0, 194, 0);
    add(0, 1, 100, 0, 0, 197, 0);
    add(0, 1, 100, 0, 0, 199, 0);
    add(0, 1, 100, 0, 0,   0, 1);
    // Enable hold: three enabled edges, five disabled, then resume.
    add(1, 1, 100, 0, 0, 100, 0);
    add(0, 1, 100, 0, 0, 150, 0);
    add(0, 1, 100, 0, 0, 175, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 100, 0, 0, 175, 0);
    add(0, 1, 100, 0, 0, 188, 0);
    // Chaining with weight=0: neuron 1 never moves.
    add(1, 1, 255, 0, 1, 0, 1);
    add(0, 1, 255, 0, 1, 0, 0);
    add(0, 1, 255, 0, 1, 0, 0);
    add(0, 1, 255, 0, 1, 0, 1);
    add(0, 1, 255, 0, 1, 0, 0);
    // Chaining with weight=255: spike[1] one edge after spike[0] (last group).
    add(1, 1, 255, 255, 0, 0, 2'b01);
    add(0, 1, 255, 255, 0, 0, 2'b10);
    add(0, 1, 255, 255, 0, 0, 2'b00);
    add(0, 1, 255, 255, 0, 0, 2'b01);
    add(0, 1, 255, 255, 0, 0, 2'b10);
    add(0, 1, 255, 255, 0, 0, 2'b00);
    add(0, 1, 255, 255, 0, 0, 2'b01);
    add(0, 1, 255, 255, 0, 0, 2'b10);
    add(0, 1, 255, 255, 0, 0, 2'b00);

    repeat (2) @(posedge clk);
    do_reset();

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      en = tbl[i].en; current = W'(tbl[i].cur); weight = W'(tbl[i].wt);
      probe_sel = 1'(tbl[i].psel);
      step();
      chk($sformatf("tbl%0d_state", i), int'(state_out), tbl[i].exp_state);
      chk($sformatf("tbl%0d_spike", i), int'(spike), tbl[i].exp_spike);
    end
`ifdef LIF_SPIKE_COUNT_EN
    exp_count = 3;
`else
    exp_count = 0;
`endif
    chk("chain_count", int'(spike_count), exp_count);

    // Refractory: current=255 gives spike[0] on edges 1,4,7.
    do_reset();
    en = 1'b1; current = 8'd255; weight = 8'd0; probe_sel = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      step();
      chk($sformatf("refr_e%0d_spike0", e), int'(spike[0]), ((e % 3) == 1) ? 1 : 0);
      chk($sformatf("refr_e%0d_state", e), int'(state_out), 0);
    end

    // Mid-refractory asynchronous reset: outputs clear without a clock edge.
    do_reset();
    en = 1'b1; current = 8'd255; weight = 8'd255; probe_sel = 1'b0;
    step();
    step();
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_spike", int'(spike), 0);
    chk("midrst_state", int'(state_out), 0);
    chk("midrst_count", int'(spike_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("midrst_first_spike", int'(spike), 2'b01);

    // Leak from a non-zero state with partial input, then a held edge.
    do_reset();
    en = 1'b1; current = 8'd150; probe_sel = 1'b0;
    step();
    chk("part_e1_state", int'(state_out), 150);
    current = 8'd124;
    step();
    chk("part_e2_state", int'(state_out), 199);
    current = 8'd126;
    step();
    chk("part_e3_spike", int'(spike), 2'b01);

    // Random phase against the reference model.
    do_reset();
    model_reset();
    for (int i = 0; i < 400; i++) begin
      en        = ($urandom_range(0, 9) != 0);
      current   = W'($urandom_range(0, 255));
      weight    = W'($urandom_range(0, 255));
      probe_sel = 1'($urandom_range(0, 1));
      model_step(en, int'(current), int'(weight));
      step();
      chk($sformatf("rnd%0d_spike", i), int'(spike), model_spike_vec());
      chk($sformatf("rnd%0d_state", i), int'(state_out), m_st[int'(probe_sel)]);
      chk($sformatf("rnd%0d_count", i), int'(spike_count), m_cnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
